// File: rtl/gearbox_arbiter.sv
// Two-producer arbiter in front of a shared 16->20 gearbox.
// Grants 5-word bursts, tags every 20-bit output word with its owner.
//
// Ports:
//   clk, res_n                 clock, async active-low reset
//   req0/data0/ack0            producer 0 (16-bit words)
//   req1/data1/ack1            producer 1 (16-bit words)
//   gb_shift_in/gb_data_in     push side of the gearbox
//   gb_full                    gearbox input backpressure
//   gb_valid_out/gb_data_out   gearbox output word
//   gb_shift_out               pop the gearbox output word
//   sink_valid/sink_data       output word to the sink
//   sink_src/sink_ready        owner of the word, sink accept
//   busy                       burst in progress or tags in flight
module gearbox_arbiter #(
  parameter int IN_PER_BURST  = 5,
  parameter int OUT_PER_BURST = 4,
  parameter int TAG_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        gb_shift_in,
  output logic [15:0] gb_data_in,
  input  logic        gb_full,
  input  logic        gb_valid_out,
  input  logic [19:0] gb_data_out,
  output logic        gb_shift_out,
  output logic        sink_valid,
  output logic [19:0] sink_data,
  output logic        sink_src,
  input  logic        sink_ready,
  output logic        busy
);

  localparam int ICW = $clog2(IN_PER_BURST);
  localparam int OCW = $clog2(OUT_PER_BURST);
  localparam int AW  = $clog2(TAG_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]           state;
  logic [ICW-1:0]       in_cnt;
  logic [OCW-1:0]       out_cnt;
  logic                 last_grant;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          tag_cnt;

  logic idle;
  logic g0;
  logic g1;
  logic xfer;
  logic in_last;
  logic out_last;
  logic tag_empty;
  logic tag_full;
  logic pick0;
  logic pick1;
  logic push;
  logic pop;

  assign idle      = (state == IDLE);
  assign g0        = (state == GRANT0);
  assign g1        = (state == GRANT1);
  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
  assign in_last   = (in_cnt == ICW'(IN_PER_BURST - 1));
  assign out_last  = (out_cnt == OCW'(OUT_PER_BURST - 1));

  // last_grant=1 favours source 0 on a tie, and vice versa
  assign pick0 = idle & ~tag_full & req0 & (~req1 | last_grant);
  assign pick1 = idle & ~tag_full & req1 & ~(req0 & last_grant);
  assign push  = pick0 | pick1;

  assign ack0        = g0 & req0 & ~gb_full;
  assign ack1        = g1 & req1 & ~gb_full;
  assign xfer        = ack0 | ack1;
  assign gb_shift_in = xfer;

  always_comb begin
    gb_data_in = '0;
    unique case (1'b1)
      g0:      gb_data_in = data0;
      g1:      gb_data_in = data1;
      default: gb_data_in = '0;
    endcase
  end

  // words leaving the gearbox with no owner on record are held back
  assign sink_valid   = gb_valid_out & ~tag_empty;
  assign gb_shift_out = sink_valid & sink_ready;
  assign sink_data    = gb_data_out;
  assign sink_src     = ~tag_empty & tag_mem[rd_ptr];
  assign pop          = gb_shift_out & out_last;

  assign busy = ~idle | ~tag_empty;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      in_cnt     <= '0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick0) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
          end else if (pick1) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (xfer) begin
            if (in_last) begin
              in_cnt <= '0;
              state  <= IDLE;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_cnt <= '0;
    end else if (gb_shift_out) begin
      out_cnt <= out_last ? '0 : out_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= pick1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_gearbox_arbiter.sv
// Directed bench for gearbox_arbiter with a bit-level 16->20 gearbox model.
// Expected words are hand-computed from the 80-bit burst concatenations.
module tb_gearbox_arbiter;

  logic        clk = 1'b0;
  logic        res_n;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1;
  logic        gb_shift_in;
  logic [15:0] gb_data_in;
  logic        gb_full;
  logic        gb_valid_out;
  logic [19:0] gb_data_out;
  logic        gb_shift_out;
  logic        sink_valid;
  logic [19:0] sink_data;
  logic        sink_src;
  logic        sink_ready;
  logic        busy;
  logic        bp;

  int checks = 0;
  int failures = 0;

  logic [19:0] obs_data[$];
  logic        obs_src[$];
  logic [19:0] exp_data[$];
  logic        exp_src[$];

  always #5 clk = ~clk;

  gearbox_arbiter dut (
    .clk          (clk),
    .res_n        (res_n),
    .req0         (req0),
    .data0        (data0),
    .ack0         (ack0),
    .req1         (req1),
    .data1        (data1),
    .ack1         (ack1),
    .gb_shift_in  (gb_shift_in),
    .gb_data_in   (gb_data_in),
    .gb_full      (gb_full),
    .gb_valid_out (gb_valid_out),
    .gb_data_out  (gb_data_out),
    .gb_shift_out (gb_shift_out),
    .sink_valid   (sink_valid),
    .sink_data    (sink_data),
    .sink_src     (sink_src),
    .sink_ready   (sink_ready),
    .busy         (busy)
  );

  // gearbox model: MSB-first bit stream, 16 in / 20 out
  logic [511:0] gbuf;
  int           gcnt;
  logic [511:0] gsh;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      gbuf <= '0;
      gcnt <= 0;
    end else begin
      if (gb_shift_in) gbuf <= {gbuf[495:0], gb_data_in};
      gcnt <= gcnt + (gb_shift_in ? 16 : 0) - (gb_shift_out ? 20 : 0);
    end
  end

  assign gb_valid_out = (gcnt >= 20);
  assign gb_full      = bp | (gcnt > 400);

  always_comb begin
    gsh         = '0;
    gb_data_out = '0;
    if (gcnt >= 20) begin
      gsh         = gbuf >> (gcnt - 20);
      gb_data_out = gsh[19:0];
    end
  end

  always @(negedge clk) begin
    if (res_n && gb_shift_out) begin
      obs_data.push_back(sink_data);
      obs_src.push_back(sink_src);
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      tick();
    end
    chk({tag, "_drain_busy"}, busy, 0);
  endtask

  task automatic expect_words(input logic [19:0] d, input logic s,
                              input int n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(d);
      exp_src.push_back(s);
    end
  endtask

  task automatic cmp_sink(input string tag);
    chk({tag, "_count"}, obs_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < obs_data.size()) begin
        chk({tag, "_data"}, obs_data[i], exp_data[i]);
        chk({tag, "_src"}, obs_src[i], exp_src[i]);
      end
    end
    obs_data = {};
    obs_src  = {};
    exp_data = {};
    exp_src  = {};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] w2[5];
  logic [15:0] w4[5];
  logic [19:0] seq;
  int          n;
  int          a0;
  int          a1;
  int          acks;

  initial begin
    w2 = '{16'h4321, 16'h8765, 16'hCBA9, 16'h0FED, 16'h1234};
    w4 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};

    // 1: reset, inputs active, every output must stay low
    res_n      = 1'b0;
    req0       = 1'b1;
    req1       = 1'b1;
    data0      = 16'hFFFF;
    data1      = 16'hFFFF;
    sink_ready = 1'b1;
    bp         = 1'b0;
    repeat (10) tick();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_shift_in", gb_shift_in, 0);
    chk("rst_data_in", gb_data_in, 0);
    chk("rst_shift_out", gb_shift_out, 0);
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_sink_src", sink_src, 0);
    chk("rst_sink_data", sink_data, 0);
    chk("rst_busy", busy, 0);
    req0  = 1'b0;
    req1  = 1'b0;
    res_n = 1'b1;
    tick();
    settle();
    chk("rel_busy", busy, 0);
    chk("rel_ack0", ack0, 0);

    // 2: single source burst
    obs_data = {};
    obs_src  = {};
    req0  = 1'b1;
    data0 = w2[0];
    settle();
    chk("t2_grant_ack0", ack0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      data0 = w2[i];
      settle();
      chk("t2_ack0", ack0, 1);
      chk("t2_ack1", ack1, 0);
      chk("t2_data_in", gb_data_in, w2[i]);
      tick();
    end
    req0 = 1'b0;
    drain("t2", 30);
    expect_words(20'h43218, 1'b0, 1);
    expect_words(20'h765CB, 1'b0, 1);
    expect_words(20'hA90FE, 1'b0, 1);
    expect_words(20'hD1234, 1'b0, 1);
    cmp_sink("t2_sink");

    // 3: contention from a fresh reset, round robin 0,1,0,1
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    tick();
    obs_data = {};
    obs_src  = {};
    req0 = 1'b1;
    req1 = 1'b1;
    a0   = 0;
    a1   = 0;
    n    = 0;
    seq  = '0;
    for (int c = 0; c < 60 && n < 20; c++) begin
      data0 = (a0 < 5) ? 16'hAAAA : 16'h1111;
      data1 = (a1 < 5) ? 16'h5555 : 16'h2222;
      settle();
      chk("t3_no_overlap", ack0 & ack1, 0);
      if (ack0) begin
        seq = {seq[18:0], 1'b0};
        a0++;
        n++;
      end else if (ack1) begin
        seq = {seq[18:0], 1'b1};
        a1++;
        n++;
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t3_ack_total", n, 20);
    chk("t3_ack_order", seq, 20'b00000111110000011111);
    drain("t3", 40);
    expect_words(20'hAAAAA, 1'b0, 4);
    expect_words(20'h55555, 1'b1, 4);
    expect_words(20'h11111, 1'b0, 4);
    expect_words(20'h22222, 1'b1, 4);
    cmp_sink("t3_sink");

    // 4: backpressure for 3 cycles after word 2
    acks  = 0;
    req0  = 1'b1;
    data0 = w4[0];
    settle();
    chk("t4_grant_ack0", ack0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      data0 = w4[i];
      settle();
      chk("t4_ack0_pre", ack0, 1);
      if (ack0) acks++;
      tick();
    end
    bp    = 1'b1;
    data0 = w4[2];
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_ack0_bp", ack0, 0);
      chk("t4_shift_in_bp", gb_shift_in, 0);
      if (ack0) acks++;
      tick();
    end
    bp = 1'b0;
    for (int i = 2; i < 5; i++) begin
      data0 = w4[i];
      settle();
      chk("t4_ack0_post", ack0, 1);
      if (ack0) acks++;
      tick();
    end
    settle();
    chk("t4_burst_end_ack0", ack0, 0);
    req0 = 1'b0;
    chk("t4_ack_total", acks, 5);
    drain("t4", 30);
    expect_words(20'h00010, 1'b0, 1);
    expect_words(20'h00200, 1'b0, 1);
    expect_words(20'h03000, 1'b0, 1);
    expect_words(20'h40005, 1'b0, 1);
    cmp_sink("t4_sink");

    // 5: tag FIFO full holds off the 5th grant
    sink_ready = 1'b0;
    req1       = 1'b1;
    for (int b = 0; b < 4; b++) begin
      data1 = {4{4'(b + 1)}};
      settle();
      chk("t5_grant_ack1", ack1, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
        settle();
        chk("t5_ack1", ack1, 1);
        tick();
      end
    end
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t5_full_ack1", ack1, 0);
      chk("t5_full_busy", busy, 1);
      chk("t5_full_valid", sink_valid, 1);
      chk("t5_full_src", sink_src, 1);
      tick();
    end
    sink_ready = 1'b1;
    data1      = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t5_wait_ack1", ack1, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t5_fifth_ack1", ack1, 1);
      tick();
    end
    req1 = 1'b0;
    drain("t5", 80);
    expect_words(20'h11111, 1'b1, 4);
    expect_words(20'h22222, 1'b1, 4);
    expect_words(20'h33333, 1'b1, 4);
    expect_words(20'h44444, 1'b1, 4);
    expect_words(20'h55555, 1'b1, 4);
    cmp_sink("t5_sink");

    // 6: reset after 2 acks, then a clean burst to source 0
    req0  = 1'b1;
    data0 = 16'h1357;
    settle();
    chk("t6_grant_ack0", ack0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t6_pre_ack0", ack0, 1);
      tick();
    end
    res_n = 1'b0;
    settle();
    chk("t6_rst_ack0", ack0, 0);
    chk("t6_rst_shift_in", gb_shift_in, 0);
    chk("t6_rst_data_in", gb_data_in, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", sink_valid, 0);
    chk("t6_rst_src", sink_src, 0);
    chk("t6_rst_shift_out", gb_shift_out, 0);
    tick();
    tick();
    res_n    = 1'b1;
    obs_data = {};
    obs_src  = {};
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 16'h2468;
    data1 = 16'h9999;
    settle();
    chk("t6_regrant_ack0", ack0, 0);
    chk("t6_regrant_ack1", ack1, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t6_ack0", ack0, 1);
      chk("t6_ack1", ack1, 0);
      tick();
    end
    settle();
    chk("t6_burst_len_ack0", ack0, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    drain("t6", 30);
    expect_words(20'h24682, 1'b0, 1);
    expect_words(20'h46824, 1'b0, 1);
    expect_words(20'h68246, 1'b0, 1);
    expect_words(20'h82468, 1'b0, 1);
    cmp_sink("t6_sink");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
